// File: rtl/mult_rr_scheduler.sv
// ============================================================================
// mult_rr_scheduler
// Round-robin arbitration of N requesters onto one shared LSB-first
// shift-add multiplier; products return tagged with the requester ID.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_rr_scheduler #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  output logic [IW-1:0]    rsp_id,
  output logic [2*W-1:0]   rsp_p,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q,      state_d;
  logic [2*W-1:0]  acc_q,        acc_d;
  logic [2*W-1:0]  mcand_q,      mcand_d;
  logic [W-1:0]    mplier_q,     mplier_d;
  logic [CW-1:0]   cnt_q,        cnt_d;
  logic [IW-1:0]   id_q,         id_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic            rsp_valid_q,  rsp_valid_d;
  logic [IW-1:0]   rsp_id_q,     rsp_id_d;
  logic [2*W-1:0]  rsp_p_q,      rsp_p_d;

  logic [W-1:0]    a_arr [N];
  logic [W-1:0]    b_arr [N];
  logic [IW-1:0]   cand;
  logic [IW-1:0]   grant_idx;
  logic            grant_found;
  logic [2*W-1:0]  step_acc;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  // Walk the requesters starting just after the last grant, wrapping at N-1.
  always_comb begin
    cand        = last_grant_q;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_p_d      = rsp_p_q;
    req_ready    = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          acc_d        = '0;
          mcand_d      = {{W{1'b0}}, a_arr[grant_idx]};
          mplier_d     = b_arr[grant_idx];
          id_d         = grant_idx;
          cnt_d        = CW'(W);
          last_grant_d = grant_idx;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Final step publishes the sum including this cycle's partial product.
        if (cnt_q == CW'(1)) begin
          rsp_p_d     = step_acc;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      last_grant_q <= IW'(N - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_p_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_p_q      <= rsp_p_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
// ============================================================================
// tb_mult_rr_scheduler
// Directed, table-driven bench for the round-robin multiply scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_p;
  logic        rsp_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         r;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [8];

  mult_rr_scheduler #(.W(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int r, input logic [3:0] a, input logic [3:0] b);
    req_valid[r]     = 1'b1;
    req_a[r*4 +: 4]  = a;
    req_b[r*4 +: 4]  = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Waits for a grant, checks it, then follows the job to its handshake.
  task automatic serve(input int exp_id, input logic [7:0] exp_p, input string tag,
                       output int acc_cyc);
    int n;
    int lat;
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " grant"}, 32'(req_ready), 32'(1 << exp_id));
    acc_cyc = cyc;
    tick();
    req_valid[exp_id] = 1'b0;
    #1;
    chk({tag, " ready low in run"}, 32'(req_ready), 32'd0);
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    wait_rsp(lat);
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " product"}, 32'(rsp_p), 32'(exp_p));
    chk({tag, " id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, " busy at rsp"}, 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    tick();
    chk({tag, " rsp dropped"}, 32'(rsp_valid), 32'd0);
    chk({tag, " busy after hs"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ac;
    int prev_ac;
    int lat;
    int seen;
    logic [7:0] rr_p [4];

    vecs[0] = '{0, 4'd13, 4'd11, 8'd143};
    vecs[1] = '{2, 4'd0,  4'd15, 8'd0};
    vecs[2] = '{3, 4'd15, 4'd15, 8'd225};
    vecs[3] = '{1, 4'd15, 4'd0,  8'd0};
    vecs[4] = '{2, 4'd9,  4'd6,  8'd54};
    vecs[5] = '{0, 4'd1,  4'd1,  8'd1};
    vecs[6] = '{3, 4'd8,  4'd8,  8'd64};
    vecs[7] = '{1, 4'd7,  4'd9,  8'd63};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;

    // Reset state
    do_reset();
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset rsp_p", 32'(rsp_p), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);

    // Single request 13*11, response held until rsp_ready is raised in serve
    rsp_ready = 1'b0;
    set_req(0, 4'd13, 4'd11);
    serve(0, 8'd143, "single", ac);

    // Table of single-requester jobs
    for (int i = 0; i < 8; i++) begin
      req_valid = '0;
      set_req(vecs[i].r, vecs[i].a, vecs[i].b);
      serve(vecs[i].r, vecs[i].p, "vec", ac);
    end

    // Round-robin with all four valid and rsp_ready high
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 4'd3, 4'd5);
    set_req(1, 4'd15, 4'd15);
    set_req(2, 4'd0, 4'd9);
    set_req(3, 4'd7, 4'd1);
    rr_p[0] = 8'd15; rr_p[1] = 8'd225; rr_p[2] = 8'd0; rr_p[3] = 8'd7;
    prev_ac = 0;
    for (int k = 0; k < 4; k++) begin
      serve(k, rr_p[k], "rr", ac);
      if (k > 0) chk("rr spacing", 32'(ac - prev_ac), 32'd6);
      prev_ac = ac;
    end

    // Priority wrap: pointer left at 2, then 0,1,3 all pending
    do_reset();
    set_req(2, 4'd1, 4'd2);
    serve(2, 8'd2, "wrap setup", ac);
    set_req(0, 4'd2, 4'd3);
    set_req(1, 4'd4, 4'd5);
    set_req(3, 4'd10, 4'd10);
    serve(3, 8'd100, "wrap first", ac);
    serve(0, 8'd6, "wrap second", ac);
    serve(1, 8'd20, "wrap third", ac);

    // Backpressure: response held 10 cycles while another request waits
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(2, 4'd9, 4'd6);
    #1;
    chk("bp grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    set_req(0, 4'd2, 4'd3);
    wait_rsp(lat);
    chk("bp latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp rsp_valid held", 32'(rsp_valid), 32'd1);
      chk("bp rsp_p held", 32'(rsp_p), 32'd54);
      chk("bp rsp_id held", 32'(rsp_id), 32'd2);
      chk("bp ready blocked", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp ready before hs", 32'(req_ready), 32'd0);
    tick();
    chk("bp next grant", 32'(req_ready), 32'b0001);
    serve(0, 8'd6, "bp next", ac);

    // Reset two cycles after an accept drops the job
    req_valid = '0;
    set_req(1, 4'd5, 4'd5);
    #1;
    chk("midrst grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("midrst no response", 32'(seen), 32'd0);
    set_req(0, 4'd3, 4'd3);
    set_req(1, 4'd2, 4'd2);
    set_req(2, 4'd1, 4'd4);
    #1;
    chk("midrst pointer", 32'(req_ready), 32'b0001);
    serve(0, 8'd9, "midrst r0", ac);
    serve(1, 8'd4, "midrst r1", ac);
    serve(2, 8'd4, "midrst r2", ac);

    // Exhaustive operands on requester 1
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_valid = '0;
        set_req(1, 4'(a), 4'(b));
        serve(1, 8'(a * b), "exh", ac);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Shares one shift-add multiply engine (LSB-first, one partial product per cycle) among N requesters. A round-robin arbiter picks one requester and latches its operands. The block sequences the engine for W cycles, then returns the product tagged with the requester ID on a valid/ready response channel. It sits between the multiplier-client blocks and the single shared multiply resource.

Parameters:
W, 4, operand width in bits; product width is 2*W
N, 4, number of requesters (N >= 1)
IW, max(1, clog2(N)), requester-ID width (localparam)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
req_valid  input  N  bit i: requester i has an operand pair pending
req_a  input  N*W  requester i multiplicand A at bits [i*W +: W]
req_b  input  N*W  requester i multiplier B at bits [i*W +: W]
req_ready  output  N  one-hot accept strobe; bit i high means requester i is accepted this cycle
rsp_valid  output  1  product available
rsp_id  output  IW  index of the requester that owns rsp_p
rsp_p  output  2*W  unsigned product A*B
rsp_ready  input  1  consumer accepts the response
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; rsp_valid=0, rsp_id=0, rsp_p=0.
  - Internal accumulator, shifted multiplicand, shifted multiplier and counter are all cleared.
  - Last-grant pointer is set to N-1, so requester 0 has highest priority first.
  - Reset overrides everything, including mid-RUN or mid-DONE: the in-flight job is dropped and no response is issued.
- States are IDLE, RUN and DONE.
- IDLE:
  - req_ready is combinational and one-hot: it selects the first requester with req_valid=1, searching from last_grant+1 upward and wrapping modulo N.
  - req_ready is all-zero when no req_valid is high, and all-zero in any state other than IDLE.
  - At an edge where req_ready[g]=1, the block latches:
    - acc <= 0
    - mcand <= zero-extended req_a[g] (2*W bits)
    - mplier <= req_b[g]
    - id <= g
    - cnt <= W
    - last_grant <= g
    - state <= RUN
- RUN, one step per cycle:
  - If mplier[0]=1, acc <= acc + mcand (2*W-bit add, no overflow possible).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt - 1.
  - At the edge where cnt==1: rsp_p <= final acc (including that cycle's conditional add), rsp_id <= id, rsp_valid <= 1, state <= DONE.
- DONE:
  - rsp_valid, rsp_id and rsp_p stay stable until rsp_ready=1.
  - At the edge where rsp_valid and rsp_ready are both 1: rsp_valid <= 0 and state <= IDLE.
  - rsp_p and rsp_id keep their last values after that; they are don't-care while rsp_valid=0.
- Latency and throughput:
  - rsp_valid rises exactly W edges after the accept edge.
  - The earliest next accept is the cycle after the response handshake, giving W+2 cycles per job when rsp_ready is held high.
- Requester rule: once raised, req_valid is held until accepted. The arbiter tolerates early withdrawal; a requester that deasserts before it is granted is simply not granted.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 jobs.
- Boundary cases:
  - A=0 or B=0 gives P=0, still after W cycles (no early exit).
  - A=B=2^W-1 gives P=(2^W-1)^2.
  - N=1: always grants requester 0 and rsp_id=0.
- busy = (state != IDLE).

Test Plan:
- Single request: rst_n low 2 cycles, then req_valid=4'b0001 with A0=13, B0=11. Required: req_ready=4'b0001 for one cycle; rsp_valid rises 4 edges later with rsp_p=143, rsp_id=0; busy high from the accept through the response handshake.
- Round-robin: all four requesters valid with (A,B) = (3,5), (15,15), (0,9), (7,1) and rsp_ready tied high. Required: responses in order id 0,1,2,3 with products 15, 225, 0, 7; each accept is 6 cycles after the previous one.
- Priority wrap: last grant=2, then req_valid=4'b1011. Required: requester 3 is granted, then 0, then 1.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises (A=9, B=6). Required: rsp_p=54 and rsp_id held stable; req_ready stays 0 while requests are pending; the next grant comes the cycle after rsp_ready rises.
- Reset mid-operation: rst_n low for 1 cycle two cycles after an accept. Required: rsp_valid never asserts for that job; state IDLE; pointer reset so requester 0 wins next.
- Exhaustive: for every A,B in 0..15 on requester 1 alone. Required: rsp_p == A*B and rsp_id=1.
